// File: rtl/display_scheduler.sv
// Time-shares the 8-digit display between the game view, a blinking winner
// banner and a timed score view; win pulses preempt, a score request is edge-triggered.
module display_scheduler #(
    parameter int unsigned BANNER_CYCLES = 200_000_000,
    parameter int unsigned SCORE_CYCLES  = 100_000_000,
    parameter int unsigned BLINK_CYCLES  = 25_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [47:0] game_d,
    input  logic        p1_win,
    input  logic        p2_win,
    input  logic [3:0]  p1_score,
    input  logic [3:0]  p2_score,
    input  logic        show_score,
    output logic [47:0] d_out,
    output logic [1:0]  view,
    output logic        busy
);

    localparam int unsigned MAX_CYCLES = (BANNER_CYCLES > SCORE_CYCLES) ? BANNER_CYCLES : SCORE_CYCLES;
    localparam int unsigned DWELL_W    = $clog2(MAX_CYCLES);
    localparam int unsigned BLINK_W    = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam int unsigned DATA_W     = 48;

    typedef enum logic [1:0] {
        ST_GAME   = 2'd0,
        ST_BANNER = 2'd1,
        ST_SCORE  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic [BLINK_W-1:0]   blink_q, blink_d;
    logic                 phase_q, phase_d;
    logic [1:0]           win_id_q, win_id_d;
    logic                 shw_q;
    logic [DATA_W-1:0]    d_out_q, d_out_d;

    logic       win;
    logic       req;
    logic [1:0] win_code;
    logic [5:0] ban_dig;

    assign win      = p1_win | p2_win;
    assign req      = show_score & ~shw_q;
    assign win_code = (p1_win && !p2_win) ? 2'd1 : ((p2_win && !p1_win) ? 2'd2 : 2'd0);

    // Next-state, dwell/blink timers and winner latch
    always_comb begin
        state_d  = state_q;
        dwell_d  = dwell_q;
        blink_d  = blink_q;
        phase_d  = phase_q;
        win_id_d = win_id_q;
        unique case (state_q)
            ST_GAME: begin
                dwell_d = '0;
                blink_d = '0;
                phase_d = 1'b1;
                if (win) begin
                    state_d  = ST_BANNER;
                    win_id_d = win_code;
                end else if (req) begin
                    state_d = ST_SCORE;
                end
            end
            ST_BANNER: begin
                if (blink_q == BLINK_W'(BLINK_CYCLES - 1)) begin
                    blink_d = '0;
                    phase_d = ~phase_q;
                end else begin
                    blink_d = blink_q + BLINK_W'(1);
                end
                if (dwell_q == DWELL_W'(BANNER_CYCLES - 1)) begin
                    state_d = ST_SCORE;
                    dwell_d = '0;
                end else begin
                    dwell_d = dwell_q + DWELL_W'(1);
                end
            end
            ST_SCORE: begin
                blink_d = '0;
                phase_d = 1'b1;
                if (win) begin
                    state_d  = ST_BANNER;
                    win_id_d = win_code;
                    dwell_d  = '0;
                end else if (dwell_q == DWELL_W'(SCORE_CYCLES - 1)) begin
                    state_d = ST_GAME;
                    dwell_d = '0;
                end else begin
                    dwell_d = dwell_q + DWELL_W'(1);
                end
            end
            default: begin
                state_d = ST_GAME;
                dwell_d = '0;
                blink_d = '0;
                phase_d = 1'b1;
            end
        endcase
    end

    // Display word selected from the current state; dark banner phase blanks all digits
    always_comb begin
        ban_dig = {1'b1, 2'b00, win_id_q, 1'b0};
        d_out_d = '0;
        unique case (state_q)
            ST_GAME:   d_out_d = game_d;
            ST_BANNER: d_out_d = phase_q ? {8{ban_dig}} : '0;
            ST_SCORE:  d_out_d = {6'h22, 1'b1, p1_score, 1'b0, 12'h000,
                                  6'h24, 1'b1, p2_score, 1'b0, 12'h000};
            default:   d_out_d = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_GAME;
            dwell_q  <= '0;
            blink_q  <= '0;
            phase_q  <= 1'b1;
            win_id_q <= 2'd0;
            shw_q    <= 1'b1;
            d_out_q  <= '0;
        end else begin
            state_q  <= state_d;
            dwell_q  <= dwell_d;
            blink_q  <= blink_d;
            phase_q  <= phase_d;
            win_id_q <= win_id_d;
            shw_q    <= show_score;
            d_out_q  <= d_out_d;
        end
    end

    assign d_out = d_out_q;
    assign view  = 2'(state_q);
    assign busy  = (state_q != ST_GAME);

endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench for display_scheduler with short banner/score/blink timings.
module tb_display_scheduler;

    logic        clock;
    logic        reset;
    logic [47:0] game_d;
    logic        p1_win;
    logic        p2_win;
    logic [3:0]  p1_score;
    logic [3:0]  p2_score;
    logic        show_score;
    logic [47:0] d_out;
    logic [1:0]  view;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [47:0] exp_q[$];

    display_scheduler #(
        .BANNER_CYCLES(8),
        .SCORE_CYCLES (6),
        .BLINK_CYCLES (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .game_d    (game_d),
        .p1_win    (p1_win),
        .p2_win    (p2_win),
        .p1_score  (p1_score),
        .p2_score  (p2_score),
        .show_score(show_score),
        .d_out     (d_out),
        .view      (view),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [47:0] gd;
    } game_vec_t;

    typedef struct {
        logic [3:0]  p1;
        logic [3:0]  p2;
        logic [47:0] exp;
    } score_vec_t;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic sb_check(input string name);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got %h", name, d_out);
        end else begin
            check(name, d_out, exp_q.pop_front());
        end
    endtask

    task automatic dwell_len(input logic [1:0] v, output int n);
        n = 0;
        while (view == v && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_view(input logic [1:0] v);
        int n;
        n = 0;
        while (view != v && n < 50) begin
            n++;
            tick();
        end
        check("wait_view", 48'(view), 48'(v));
    endtask

    // Walks all 8 banner cycles checking blink pattern; optional p2_win injection at cycle inj
    task automatic banner_check(input int id, input int inj);
        logic [5:0] dig;
        dig = {1'b1, 4'(id), 1'b0};
        for (int j = 0; j < 8; j++) begin
            check("banner_view", 48'(view), 48'd1);
            if (j == inj) p2_win = 1'b1;
            exp_q.push_back(((j / 2) % 2 == 0) ? {8{dig}} : 48'h0);
            tick();
            p2_win = 1'b0;
            sb_check("banner_dout");
        end
        check("banner_to_score", 48'(view), 48'd2);
    endtask

    game_vec_t  gvec[5];
    score_vec_t svec[4];
    int n;

    initial begin
        gvec[0].gd = 48'h123456789ABC;
        gvec[1].gd = 48'h000000000000;
        gvec[2].gd = 48'hFFFFFFFFFFFF;
        gvec[3].gd = 48'hA5A5A5A5A5A5;
        gvec[4].gd = 48'h0F0F0F0F0F0F;

        svec[0] = '{4'd3, 4'd5, {6'h22, 6'h26, 6'h00, 6'h00, 6'h24, 6'h2A, 6'h00, 6'h00}};
        svec[1] = '{4'd0, 4'd0, {6'h22, 6'h20, 6'h00, 6'h00, 6'h24, 6'h20, 6'h00, 6'h00}};
        svec[2] = '{4'd15, 4'd9, {6'h22, 6'h3E, 6'h00, 6'h00, 6'h24, 6'h32, 6'h00, 6'h00}};
        svec[3] = '{4'd7, 4'd12, {6'h22, 6'h2E, 6'h00, 6'h00, 6'h24, 6'h38, 6'h00, 6'h00}};

        reset      = 1'b1;
        game_d     = 48'hDEADBEEF0123;
        p1_win     = 1'b0;
        p2_win     = 1'b0;
        p1_score   = 4'd0;
        p2_score   = 4'd0;
        show_score = 1'b1;
        #2 reset = 1'b0;

        // Reset held low with show_score high
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_dout", d_out, 48'h0);
            check("rst_view", 48'(view), 48'd0);
            check("rst_busy", 48'(busy), 48'd0);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_req_level", 48'(view), 48'd0);
        end

        // Fresh rise of show_score gives a 6-cycle score view
        show_score = 1'b0;
        tick();
        show_score = 1'b1;
        tick();
        check("req_view", 48'(view), 48'd2);
        check("req_busy", 48'(busy), 48'd1);
        dwell_len(2'd2, n);
        check("score_len", 48'(n), 48'd6);
        check("score_exit", 48'(view), 48'd0);

        // Game pass-through table
        for (int i = 0; i < 5; i++) begin
            game_d = gvec[i].gd;
            exp_q.push_back(gvec[i].gd);
            tick();
            sb_check("game_pass");
        end

        // Live score sampling table
        show_score = 1'b0;
        tick();
        show_score = 1'b1;
        tick();
        check("score_entry", 48'(view), 48'd2);
        for (int i = 0; i < 4; i++) begin
            p1_score = svec[i].p1;
            p2_score = svec[i].p2;
            exp_q.push_back(svec[i].exp);
            tick();
            sb_check("score_dout");
        end
        wait_view(2'd0);

        // p1 win: banner, then score, then game
        p1_score = 4'd3;
        p2_score = 4'd5;
        p1_win = 1'b1;
        tick();
        p1_win = 1'b0;
        check("win_busy", 48'(busy), 48'd1);
        banner_check(1, -1);
        exp_q.push_back({6'h22, 6'h26, 6'h00, 6'h00, 6'h24, 6'h2A, 6'h00, 6'h00});
        tick();
        sb_check("post_win_score");
        dwell_len(2'd2, n);
        check("post_win_score_len", 48'(n + 1), 48'd6);
        check("post_win_game", 48'(view), 48'd0);

        // Draw, with an ignored p2_win during the banner
        p1_win = 1'b1;
        p2_win = 1'b1;
        tick();
        p1_win = 1'b0;
        p2_win = 1'b0;
        banner_check(0, 2);
        wait_view(2'd0);

        // Score view preempted by p2_win on its 3rd cycle
        show_score = 1'b0;
        tick();
        show_score = 1'b1;
        tick();
        tick();
        tick();
        check("preempt_pre", 48'(view), 48'd2);
        p2_win = 1'b1;
        tick();
        p2_win = 1'b0;
        banner_check(2, -1);
        wait_view(2'd0);

        // Reset in the 4th banner cycle
        p1_win = 1'b1;
        tick();
        p1_win = 1'b0;
        tick();
        tick();
        tick();
        check("mid_banner", 48'(view), 48'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_view", 48'(view), 48'd0);
        check("mid_rst_busy", 48'(busy), 48'd0);
        check("mid_rst_dout", d_out, 48'h0);
        tick();
        reset = 1'b1;
        game_d = 48'hCAFEF00D1234;
        exp_q.push_back(48'hCAFEF00D1234);
        tick();
        sb_check("post_rst_pass");
        check("post_rst_view", 48'(view), 48'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
